// File: rtl/capture_trigger_ctrl.sv
// capture_trigger_ctrl: threshold-triggered snapshot controller for one readout
// channel. Streams accepted phase samples into a circular capture buffer and
// stops POST_LEN samples after the first sub-threshold sample seen once at least
// PRE_LEN pre-trigger samples have been written.
// Ports:
//   user_clk, user_rst_n        clock, async active-low reset
//   arm                         software arm level (rising edge restarts capture)
//   threshold[15:0]             signed trigger threshold ([31:16] unused)
//   ch_sel                      channel to capture
//   phase_in/phase_ch/phase_valid  input sample stream (no backpressure)
//   buf_we/buf_addr/buf_data    capture buffer write port (1 cycle after accept)
//   busy, done, trig_addr       status back to software
module capture_trigger_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int PRE_LEN  = 256,
  parameter int POST_LEN = 511
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              arm,
  input  logic [31:0]       threshold,
  input  logic [7:0]        ch_sel,
  input  logic [15:0]       phase_in,
  input  logic [7:0]        phase_ch,
  input  logic              phase_valid,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [15:0]       buf_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  // One extra bit so PRE_LEN / POST_LEN (both < 2^ADDR_W) always fit.
  localparam int CNT_W = ADDR_W + 1;

  // The post-trigger window must not reach back over the trigger sample or
  // the pre-trigger history that precedes it.
  generate
    if (PRE_LEN + POST_LEN + 1 > (1 << ADDR_W)) begin : g_len_check
      $error("capture_trigger_ctrl: PRE_LEN + POST_LEN + 1 exceeds buffer depth");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_arm_d;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  w_wr_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_arm_edge;
  logic               w_accept;
  logic               w_below;
  logic               w_wr_en;
  logic               w_trig_set;

  logic               r_buf_we;
  logic [ADDR_W-1:0]  r_buf_addr;
  logic [15:0]        r_buf_data;
  logic               r_busy;
  logic               r_done;
  logic [ADDR_W-1:0]  r_trig_addr;

  // Upper threshold bits are software padding and carry no meaning here.
  logic               w_unused_thr_hi;
  assign w_unused_thr_hi = ^threshold[31:16];

  // r_arm_d resets high so an arm level held through reset release is not
  // mistaken for a fresh arm request.
  assign w_arm_edge = arm & ~r_arm_d;
  assign w_accept   = phase_valid && (phase_ch == ch_sel);
  assign w_below    = $signed(phase_in) < $signed(threshold[15:0]);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_cnt_nxt    = r_cnt;
    w_wr_en      = 1'b0;
    w_trig_set   = 1'b0;
    if (w_arm_edge) begin
      // Restart wins over any sample arriving in the same cycle.
      w_state_nxt  = (PRE_LEN == 0) ? S_ARMED : S_FILL;
      w_wr_ptr_nxt = '0;
      w_cnt_nxt    = '0;
    end else if (w_accept) begin
      unique case (r_state)
        S_FILL: begin
          // Pre-trigger history: written but never tested.
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
          if (w_cnt_inc == CNT_W'(PRE_LEN)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_ARMED;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_ARMED: begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
          if (w_below) begin
            w_trig_set  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = (POST_LEN == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
          w_cnt_nxt    = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(POST_LEN)) begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_arm_d     <= 1'b1;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_buf_we    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trig_addr <= '0;
    end else begin
      r_arm_d  <= arm;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_buf_we <= w_wr_en;
      if (w_wr_en) begin
        r_buf_addr <= r_wr_ptr;
        r_buf_data <= phase_in;
      end
      if (w_trig_set) begin
        r_trig_addr <= r_wr_ptr;
      end
      // Status decoded from the next state so it lines up with the write pulse.
      r_busy <= (w_state_nxt == S_FILL) || (w_state_nxt == S_ARMED) ||
                (w_state_nxt == S_POST);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign buf_we    = r_buf_we;
  assign buf_addr  = r_buf_addr;
  assign buf_data  = r_buf_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign trig_addr = r_trig_addr;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Testbench for capture_trigger_ctrl with a small buffer (depth 16, 4 pre, 3 post).
// The reference model tracks captures as "n-th accepted sample since arm":
// sample n lands at n mod depth; the first n >= PRE below threshold triggers.
module tb_capture_trigger_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int POST  = 3;

  logic          user_clk   = 1'b0;
  logic          user_rst_n = 1'b0;
  logic          arm        = 1'b1;
  logic [31:0]   threshold;
  logic [7:0]    ch_sel;
  logic [15:0]   phase_in;
  logic [7:0]    phase_ch;
  logic          phase_valid;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [15:0]   buf_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  bit            m_active;
  bit            m_done;
  bit            m_arm_prev;
  int            m_n;
  int            m_trig;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_data;
  logic          e_busy;
  logic          e_done;
  logic [AW-1:0] e_trig;

  capture_trigger_ctrl #(.ADDR_W(AW), .PRE_LEN(PRE), .POST_LEN(POST)) dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .arm(arm), .threshold(threshold),
    .ch_sel(ch_sel), .phase_in(phase_in), .phase_ch(phase_ch), .phase_valid(phase_valid),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data), .busy(busy), .done(done),
    .trig_addr(trig_addr)
  );

  always #5 user_clk = ~user_clk;

  function automatic logic [26:0] dut_vec();
    return {buf_we, (buf_we ? buf_addr : 4'd0), (buf_we ? buf_data : 16'd0), busy, done, trig_addr};
  endfunction

  function automatic logic [26:0] exp_vec();
    return {e_we, (e_we ? e_addr : 4'd0), (e_we ? e_data : 16'd0), e_busy, e_done, e_trig};
  endfunction

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_arm_prev = 1; m_n = 0; m_trig = -1;
    e_we = 0; e_addr = '0; e_data = '0; e_busy = 0; e_done = 0; e_trig = '0;
  endfunction

  // Predict the outputs after the next edge from the current inputs, then clock.
  task automatic step();
    bit edge_now;
    bit acc;
    edge_now = arm && !m_arm_prev;
    acc = phase_valid && (phase_ch == ch_sel);
    m_arm_prev = arm;
    e_we = 0;
    if (edge_now) begin
      m_active = 1; m_n = 0; m_trig = -1; m_done = 0;
    end else if (m_active && !m_done && acc) begin
      e_we = 1;
      e_addr = AW'(m_n % DEPTH);
      e_data = phase_in;
      if (m_trig < 0 && m_n >= PRE && $signed(phase_in) < $signed(threshold[15:0])) begin
        m_trig = m_n;
        e_trig = AW'(m_n % DEPTH);
      end
      if (m_trig >= 0 && m_n == m_trig + POST) m_done = 1;
      m_n++;
    end
    e_busy = m_active && !m_done;
    e_done = m_done;
    @(posedge user_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch, input int val, input logic vld);
    phase_ch = ch; phase_in = 16'(val); phase_valid = vld;
    step();
  endtask

  task automatic do_arm();
    phase_valid = 0; arm = 0;
    step();
    arm = 1;
    step();
  endtask

  task automatic test_reset();
    user_rst_n = 0; arm = 1;
    repeat (3) @(posedge user_clk);
    #1;
    if ({buf_we, buf_addr, buf_data, busy, done, trig_addr} !== 27'd0) begin
      errors++; $display("FAIL reset_state: dut=%h want 0", {buf_we, buf_addr, buf_data, busy, done, trig_addr});
    end
    vectors++;
    user_rst_n = 1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      send(8'd7, int'($urandom_range(0, 65535)), 1'b1);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_arm_held[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vectors++;
    end
  endtask

  task automatic test_basic();
    int vals[10] = '{0, 1, 2, 3, 10, -300, 5, 6, 7, 8};
    int nw = 0;
    logic done_at_8 = 1'b0;
    threshold = 32'h0000FF00; ch_sel = 8'd7;
    do_arm();
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL basic_arm: dut=%h model=%h", dut_vec(), exp_vec());
    end
    vectors++;
    for (int i = 0; i < 13; i++) begin
      send(8'd7, (i < 10) ? vals[i] : 1, 1'b1);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL basic[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vectors++;
      if (buf_we) nw++;
      if (buf_we && buf_addr == 4'd8) done_at_8 = done;
    end
    phase_valid = 0;
    if (nw !== 9) begin errors++; $display("FAIL basic_write_count: dut=%0d want 9", nw); end
    vectors++;
    if (trig_addr !== 4'd5) begin errors++; $display("FAIL basic_trig_addr: dut=%0d want 5", trig_addr); end
    vectors++;
    if (done_at_8 !== 1'b1) begin errors++; $display("FAIL basic_done_with_last: dut=%b want 1", done_at_8); end
    vectors++;
  endtask

  task automatic test_fill_equal();
    threshold = 32'h1234FF00;
    do_arm();
    for (int i = 0; i < 12; i++) begin
      int v;
      if (i < 4) v = -300;
      else if (i == 4) v = -256;
      else if (i < 8) v = int'($urandom_range(0, 33023)) - 256;
      else if (i == 8) v = -300;
      else v = int'($urandom_range(0, 65535)) - 32768;
      send(8'd7, v, 1'b1);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL fill_equal[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vectors++;
      if (i == 4 && trig_addr !== 4'd5) begin
        errors++; $display("FAIL fill_equal_no_trig: trig_addr=%0d want 5", trig_addr);
      end
      if (i == 4) vectors++;
    end
    phase_valid = 0;
    if (trig_addr !== 4'd8 || done !== 1'b1) begin
      errors++; $display("FAIL fill_equal_trig: trig_addr=%0d done=%b want 8 1", trig_addr, done);
    end
    vectors++;
  endtask

  task automatic test_interleave();
    int nw = 0;
    threshold = 32'h0000FF00; ch_sel = 8'd7;
    do_arm();
    for (int i = 0; i < 40; i++) begin
      send(($urandom_range(0, 1) != 0) ? 8'd7 : 8'd3, int'($urandom_range(0, 32767)),
           1'($urandom_range(0, 3) != 0));
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL interleave[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vectors++;
      if (buf_we) begin
        if (buf_addr !== AW'(nw % DEPTH)) begin
          errors++; $display("FAIL interleave_addr: dut=%0d want %0d", buf_addr, nw % DEPTH);
        end
        vectors++;
        nw++;
      end
    end
    phase_valid = 0;
  endtask

  task automatic test_wrap();
    threshold = 32'h0000FF00; ch_sel = 8'd7;
    do_arm();
    for (int i = 0; i < 54; i++) begin
      send(8'd7, (i == 50) ? -300 : int'($urandom_range(0, 32767)), 1'b1);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vectors++;
      if (i == 16) begin
        if (buf_addr !== 4'd0) begin errors++; $display("FAIL wrap_to_zero: dut=%0d want 0", buf_addr); end
        vectors++;
      end
    end
    phase_valid = 0;
    if (trig_addr !== 4'd2 || done !== 1'b1 || buf_addr !== 4'd5) begin
      errors++; $display("FAIL wrap_end: trig=%0d done=%b last=%0d want 2 1 5", trig_addr, done, buf_addr);
    end
    vectors++;
  endtask

  task automatic test_rearm();
    threshold = 32'h0000FF00; ch_sel = 8'd7;
    do_arm();
    for (int i = 0; i < 5; i++) send(8'd7, (i == 4) ? -300 : 100, 1'b1);
    arm = 0;
    send(8'd7, 200, 1'b1);
    arm = 1;
    send(8'd7, 300, 1'b1);
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL rearm_model: dut=%h model=%h", dut_vec(), exp_vec());
    end
    vectors++;
    if (buf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rearm_drop: we=%b done=%b busy=%b want 0 0 1", buf_we, done, busy);
    end
    vectors++;
    send(8'd7, 400, 1'b1);
    if (buf_we !== 1'b1 || buf_addr !== 4'd0 || buf_data !== 16'd400) begin
      errors++; $display("FAIL rearm_restart: we=%b addr=%0d data=%0d want 1 0 400", buf_we, buf_addr, buf_data);
    end
    vectors++;
    phase_valid = 0;
  endtask

  task automatic test_reset_mid_post();
    do_arm();
    for (int i = 0; i < 6; i++) send(8'd7, (i == 4) ? -300 : 50, 1'b1);
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_post_busy: dut=%b want 1", busy); end
    vectors++;
    #1 user_rst_n = 0;
    #1;
    model_reset();
    if ({buf_we, buf_addr, buf_data, busy, done, trig_addr} !== 27'd0) begin
      errors++; $display("FAIL mid_post_reset: dut=%h want 0", {buf_we, buf_addr, buf_data, busy, done, trig_addr});
    end
    vectors++;
    @(posedge user_clk);
    #1 user_rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      send(8'd7, 77, 1'b1);
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL post_reset_idle[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vectors++;
    end
    phase_valid = 0;
  endtask

  task automatic test_random();
    ch_sel = 8'd2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) arm = ~arm;
      if ($urandom_range(0, 49) == 0) ch_sel = ($urandom_range(0, 1) != 0) ? 8'd2 : 8'd9;
      if ($urandom_range(0, 39) == 0) begin
        threshold = $urandom;
        threshold[15:0] = 16'(int'($urandom_range(0, 600)) - 300);
      end
      send(($urandom_range(0, 3) == 0) ? 8'd4 : ch_sel, int'($urandom_range(0, 2000)) - 1000,
           1'($urandom_range(0, 3) != 0));
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: dut=%h model=%h", i, dut_vec(), exp_vec());
      end
      vectors++;
    end
    phase_valid = 0;
  endtask

  initial begin
    threshold = 32'h0000FF00; ch_sel = 8'd7; phase_ch = 8'd0; phase_in = 16'd0; phase_valid = 0;
    model_reset();
    test_reset();
    test_basic();
    test_fill_equal();
    test_interleave();
    test_wrap();
    test_rearm();
    test_reset_mid_post();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
